cordic_floatingpoint_mul_k_norm_arbiter: RTL and testbench
==========================================================

# cordic_floatingpoint_mul_K_norm_arbiter

Shared post-multiply normalizer for the CORDIC floating-point K-scaling stage. The X and Y channels each present a 48-bit mantissa product with sign and pre-adjusted exponent. The block arbitrates between them round-robin and runs one leading-one search over product bits [47:24]. It then left-shifts, adjusts the exponent with saturation, and returns one tagged, normalized single-precision result per transaction over a valid/ready handshake.

## Interface
- MANT_W, 48, product mantissa width (fixed; window is bits [47:24])
- EXP_W, 8, exponent width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- x_valid  in  1  X channel request
- x_ready  out  1  X request accepted this cycle
- x_mant  in  48  X product mantissa
- x_exp  in  8  X pre-adjusted exponent (sum of operand exponents minus bias)
- x_sign  in  1  X product sign
- y_valid / y_ready / y_mant / y_exp / y_sign: same as X, for the Y channel
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_id  out  1  0 = X, 1 = Y
- out_sign  out  1  result sign
- out_exp  out  8  normalized exponent
- out_mant  out  24  normalized mantissa, hidden bit at [23]
- out_zero  out  1  product window all-zero
- out_uflow  out  1  exponent underflow, flushed to zero
- out_oflow  out  1  exponent overflow, saturated

## Operation
- FSM states:
  - IDLE: transitions to CALC on accept.
  - CALC: always transitions to NORM after 1 cycle.
  - NORM: always transitions to OUT after 1 cycle.
  - OUT: transitions to IDLE on out_valid & out_ready.
- One transaction is in flight at a time; there is no input buffering.
- Grant is combinational in IDLE:
  - Only one of x_valid / y_valid high: that channel is granted.
  - Both high: the channel not granted last time is granted.
  - Neither high: no grant.
- `last` register holds the most recently granted channel. It resets to Y, so X wins the first contention.
- x_ready = IDLE & grant_x; y_ready = IDLE & grant_y. At most one ready is high in any cycle.
- Accept = valid & ready of the granted channel. On accept, the block latches mant, exp, sign and id, and updates `last`.
- CALC:
  - lz = number of leading zeros in mant[47:24], range 0..23.
  - zero = (mant[47:24] == 0).
  - lz and zero are registered.
- NORM:
  - m = (mant << lz)[47:24].
  - e = exp + 1 − lz, computed as 10-bit signed.
  - Bits below [24] of the shifted value are truncated; there is no rounding.
- Result priority, highest first:
  - zero: mant = 0, exp = 0, zero = 1.
  - e ≤ 0: mant = 0, exp = 0, uflow = 1.
  - e ≥ 255: mant = 24'h800000, exp = 255, oflow = 1.
  - Otherwise: mant = m, exp = e[7:0].
- Sign and id pass through unchanged, including on zero, underflow and overflow results.
- The zero, uflow and oflow flags are mutually exclusive.
- All out_* signals are registered and are held stable while out_valid & !out_ready.

## Timing
- Reset values:
  - FSM = IDLE; last = Y.
  - out_valid = 0; all out_* data and flags = 0.
  - x_ready = 0 and y_ready = 0 while rst_n is low.
- Latency: accept at edge t gives lz at t+1 and out_valid high from t+2, i.e. 2 cycles after the accepting edge.
- Out handshake completes at the edge where out_valid & out_ready are both high. out_valid falls after that edge, and the next accept can occur no earlier than the following edge.
- Peak throughput is one result per 4 cycles with out_ready tied high.
- Backpressure: the block stays in OUT indefinitely. x_ready and y_ready stay 0, and requesters must hold valid and data stable.
- A request that drops valid before it is granted is allowed and causes no error. Once accepted, the data is latched, so requester inputs may change afterwards.
- Reset mid-transaction aborts it immediately. No out_valid is produced for the aborted transaction, and `last` returns to Y.

## Test plan
- X only, mant 48'h8000_0000_0000, exp 127, sign 1 -> x_ready for one cycle; out_valid 2 cycles after accept; id 0, mant 24'h800000, exp 128, sign 1, all flags 0.
- Y only, mant 48'h4000_0000_0000, exp 127 -> lz 1; id 1, mant 24'h800000, exp 127.
- X and Y held valid together for 4 transactions, out_ready high -> grant order X, Y, X, Y; one result every 4 cycles; never both readys high.
- mant 48'h0000_00FF_FFFF -> out_zero 1, mant 0, exp 0. Separately: mant 48'h0000_0100_0000, exp 10 -> lz 23, e = −12, out_uflow 1, mant 0, exp 0.
- mant 48'hC000_0000_0000, exp 254 -> out_oflow 1, exp 255, mant 24'h800000. Then hold out_ready low for 5 cycles -> outputs stable, both readys 0, single handshake when released.
- Assert rst_n low while in NORM -> out_valid stays 0 and both readys 0 during reset. After release, with X and Y both valid, X is granted first.

Source files
------------

// File: rtl/cordic_floatingpoint_mul_k_norm_arbiter_if.sv
// Purpose: X/Y product request channels and the normalized result channel of the K-scaling normalizer.
// Latency: none, wiring only.
// Backpressure: valid/ready on every channel; the producer holds valid and data until ready.
interface cordic_floatingpoint_mul_k_norm_arbiter_if #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 8
);
    logic              x_valid;
    logic              x_ready;
    logic [MANT_W-1:0] x_mant;
    logic [EXP_W-1:0]  x_exp;
    logic              x_sign;

    logic              y_valid;
    logic              y_ready;
    logic [MANT_W-1:0] y_mant;
    logic [EXP_W-1:0]  y_exp;
    logic              y_sign;

    logic              out_valid;
    logic              out_ready;
    logic              out_id;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [23:0]       out_mant;
    logic              out_zero;
    logic              out_uflow;
    logic              out_oflow;

    // Normalizer side: consumes requests, produces results.
    modport slave (
        input  x_valid, x_mant, x_exp, x_sign,
        output x_ready,
        input  y_valid, y_mant, y_exp, y_sign,
        output y_ready,
        output out_valid, out_id, out_sign, out_exp, out_mant,
        output out_zero, out_uflow, out_oflow,
        input  out_ready
    );

    // Requester/consumer side.
    modport master (
        output x_valid, x_mant, x_exp, x_sign,
        input  x_ready,
        output y_valid, y_mant, y_exp, y_sign,
        input  y_ready,
        input  out_valid, out_id, out_sign, out_exp, out_mant,
        input  out_zero, out_uflow, out_oflow,
        output out_ready
    );
endinterface

// File: rtl/cordic_floatingpoint_mul_k_norm_arbiter.sv
// Purpose: round-robin shared leading-one normalizer for the X/Y CORDIC K-scaling products.
// Latency: result valid 2 cycles after the accepting edge; one transaction in flight, 4-cycle peak period.
// Backpressure: holds the result in OUT while out_ready is low; both request readys stay low meanwhile.
module cordic_floatingpoint_mul_k_norm_arbiter #(
    parameter int MANT_W = 48,
    parameter int EXP_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    cordic_floatingpoint_mul_k_norm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Bit 0 of the product can never reach the 24-bit window (max shift is 23), so it is not kept.
    typedef struct packed {
        logic              id;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-2:0] mant;   // product bits [47:1]
    } req_t;

    state_t       state_q, state_d;
    logic         last_q;          // 0 = X granted last, 1 = Y granted last
    req_t         req_q;
    logic [4:0]   lz_q, lz_d;
    logic         zero_q, zero_d;

    logic         grant_x, grant_y;
    logic         acc_x, acc_y, accept;
    logic [23:0]  win;
    logic [23:0]  m_norm;
    logic [9:0]   e_norm;
    logic         uflow_d, oflow_d;
    logic [EXP_W-1:0] exp_d;
    logic [23:0]  mant_d;

    logic         out_valid_q;
    logic         out_id_q, out_sign_q;
    logic [EXP_W-1:0] out_exp_q;
    logic [23:0]  out_mant_q;
    logic         out_zero_q, out_uflow_q, out_oflow_q;

    // Round-robin grant: a lone requester wins; under contention the channel not granted last wins.
    always_comb begin
        grant_x = bus.x_valid & (~bus.y_valid | last_q);
        grant_y = bus.y_valid & (~bus.x_valid | ~last_q);
    end

    // Readys are gated by rst_n so nothing is offered while reset is held.
    assign bus.x_ready = rst_n & (state_q == IDLE) & grant_x;
    assign bus.y_ready = rst_n & (state_q == IDLE) & grant_y;
    assign acc_x       = bus.x_valid & bus.x_ready;
    assign acc_y       = bus.y_valid & bus.y_ready;
    assign accept      = acc_x | acc_y;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: fixed two-cycle compute, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = CALC;
            CALC: state_d = NORM;
            NORM: state_d = OUT;
            OUT:  if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request and remember who won for the next contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            last_q <= 1'b1;
        end else if (accept) begin
            if (acc_x) req_q <= {1'b0, bus.x_sign, bus.x_exp, bus.x_mant[MANT_W-1:1]};
            else       req_q <= {1'b1, bus.y_sign, bus.y_exp, bus.y_mant[MANT_W-1:1]};
            last_q <= acc_y;
        end
    end

    // Leading-zero count over the top 24 product bits; highest set bit wins.
    always_comb begin
        win    = req_q.mant[46:23];
        zero_d = (win == 24'd0);
        lz_d   = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (win[i]) lz_d = 5'(23 - i);
        end
    end

    // Register the leading-zero result during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lz_q   <= 5'd0;
            zero_q <= 1'b0;
        end else if (state_q == CALC) begin
            lz_q   <= lz_d;
            zero_q <= zero_d;
        end
    end

    // Shift, exponent adjust and saturation; lower shifted-out bits are truncated, no rounding.
    always_comb begin
        m_norm = '0;
        for (int s = 0; s < 24; s++) begin
            if (lz_q == 5'(s)) m_norm = req_q.mant[46-s -: 24];
        end
        e_norm  = {2'b00, req_q.exp} + 10'd1 - {5'd0, lz_q};
        uflow_d = 1'b0;
        oflow_d = 1'b0;
        exp_d   = '0;
        mant_d  = '0;
        if (zero_q) begin
            exp_d  = '0;
            mant_d = '0;
        end else if (e_norm[9] || (e_norm == 10'd0)) begin
            uflow_d = 1'b1;
        end else if (e_norm >= 10'd255) begin
            oflow_d = 1'b1;
            exp_d   = 8'hFF;
            mant_d  = 24'h800000;
        end else begin
            exp_d   = e_norm[7:0];
            mant_d  = m_norm;
        end
    end

    // Result register: loaded at the end of NORM, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
            out_oflow_q <= 1'b0;
        end else if (state_q == NORM) begin
            out_valid_q <= 1'b1;
            out_id_q    <= req_q.id;
            out_sign_q  <= req_q.sign;
            out_exp_q   <= exp_d;
            out_mant_q  <= mant_d;
            out_zero_q  <= zero_q;
            out_uflow_q <= uflow_d;
            out_oflow_q <= oflow_d;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_mant  = out_mant_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_uflow = out_uflow_q;
    assign bus.out_oflow = out_oflow_q;

endmodule

// File: tb/tb_cordic_floatingpoint_mul_k_norm_arbiter.sv
module tb_cordic_floatingpoint_mul_k_norm_arbiter;

    typedef struct packed {
        logic        id;
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
        logic        zero;
        logic        uflow;
        logic        oflow;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    cordic_floatingpoint_mul_k_norm_arbiter_if bus ();

    cordic_floatingpoint_mul_k_norm_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic res_t mk(input logic id, input logic sign, input logic [7:0] e,
                                input logic [23:0] m, input logic z, input logic u, input logic o);
        res_t r;
        r.id = id; r.sign = sign; r.exp = e; r.mant = m; r.zero = z; r.uflow = u; r.oflow = o;
        return r;
    endfunction

    // Reference: normalize the product from first principles with integers.
    function automatic res_t ref_model(input logic [47:0] mant, input logic [7:0] e_in,
                                       input logic sign, input logic id);
        res_t r;
        int lz;
        int e;
        logic [47:0] sh;
        r = mk(id, sign, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        if (mant[47:24] == 24'd0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        while (mant[47-lz] == 1'b0) lz++;
        sh = mant << lz;
        e  = int'(e_in) + 1 - lz;
        if (e <= 0) r.uflow = 1'b1;
        else if (e >= 255) begin
            r.oflow = 1'b1; r.exp = 8'd255; r.mant = 24'h800000;
        end else begin
            r.exp = 8'(e); r.mant = sh[47:24];
        end
        return r;
    endfunction

    function automatic res_t dut_res();
        return mk(bus.out_id, bus.out_sign, bus.out_exp, bus.out_mant,
                  bus.out_zero, bus.out_uflow, bus.out_oflow);
    endfunction

    // Model state: transaction in flight, edges since accept, last winner, expected result.
    bit   m_busy = 1'b0;
    int   m_cnt = 0;
    bit   m_last = 1'b1;
    res_t m_rec;

    // Compare process: checks every cycle, then advances the model to the coming edge.
    always @(negedge clk) begin
        bit gx, gy, exr, eyr, eov;
        if (!rst_n) begin
            check("rst_x_ready", 64'(bus.x_ready), 64'd0);
            check("rst_y_ready", 64'(bus.y_ready), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            m_busy = 1'b0;
            m_last = 1'b1;
            m_cnt  = 0;
        end else begin
            gx  = bus.x_valid && (!bus.y_valid || m_last);
            gy  = bus.y_valid && (!bus.x_valid || !m_last);
            exr = !m_busy && gx;
            eyr = !m_busy && gy;
            eov = m_busy && (m_cnt >= 2);
            check("x_ready", 64'(bus.x_ready), 64'(exr));
            check("y_ready", 64'(bus.y_ready), 64'(eyr));
            check("ready_excl", 64'(bus.x_ready & bus.y_ready), 64'd0);
            check("out_valid", 64'(bus.out_valid), 64'(eov));
            if (eov) check("out_fields", 64'(dut_res()), 64'(m_rec));
            if (exr && bus.x_valid) begin
                m_rec = ref_model(bus.x_mant, bus.x_exp, bus.x_sign, 1'b0);
                m_busy = 1'b1; m_cnt = 0; m_last = 1'b0;
            end else if (eyr && bus.y_valid) begin
                m_rec = ref_model(bus.y_mant, bus.y_exp, bus.y_sign, 1'b1);
                m_busy = 1'b1; m_cnt = 0; m_last = 1'b1;
            end else if (m_busy) begin
                if (eov && bus.out_ready) m_busy = 1'b0;
                else if (m_cnt < 3) m_cnt++;
            end
        end
    end

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic drive(input bit ch, input logic [47:0] m, input logic [7:0] e, input logic s);
        @(posedge clk); #1;
        if (!ch) begin bus.x_mant = m; bus.x_exp = e; bus.x_sign = s; bus.x_valid = 1'b1; end
        else     begin bus.y_mant = m; bus.y_exp = e; bus.y_sign = s; bus.y_valid = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((!ch && bus.x_ready) || (ch && bus.y_ready)) begin
                @(posedge clk); #1;
                if (!ch) bus.x_valid = 1'b0; else bus.y_valid = 1'b0;
                return;
            end
        end
        timeout("drive_accept");
        bus.x_valid = 1'b0;
        bus.y_valid = 1'b0;
    endtask

    // Wait for out_valid; lat counts negedges since the caller's accepting edge.
    task automatic wait_out(output res_t r, output int lat);
        r = '0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) begin
                r = dut_res();
                return;
            end
        end
        timeout("wait_out_valid");
    endtask

    function automatic logic [47:0] rand_mant();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0] >> $urandom_range(0, 30);
    endfunction

    initial begin
        res_t r, r0;
        int   lat, n, hs;
        bit   ids[4];
        int   tms[4];
        bit   ax, ay;

        bus.x_valid = 1'b0; bus.x_mant = '0; bus.x_exp = '0; bus.x_sign = 1'b0;
        bus.y_valid = 1'b0; bus.y_mant = '0; bus.y_exp = '0; bus.y_sign = 1'b0;
        bus.out_ready = 1'b1;

        // Hand-computed values that pin the reference model.
        check("model_x_only", 64'(ref_model(48'h8000_0000_0000, 8'd127, 1'b1, 1'b0)),
              64'(mk(1'b0, 1'b1, 8'd128, 24'h800000, 1'b0, 1'b0, 1'b0)));
        check("model_lz1", 64'(ref_model(48'h4000_0000_0000, 8'd127, 1'b0, 1'b1)),
              64'(mk(1'b1, 1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0)));
        check("model_trunc", 64'(ref_model(48'h0000_0180_0001, 8'd100, 1'b0, 1'b0)),
              64'(mk(1'b0, 1'b0, 8'd78, 24'hC00000, 1'b0, 1'b0, 1'b0)));
        check("model_zero", 64'(ref_model(48'h0000_00FF_FFFF, 8'd50, 1'b1, 1'b0)),
              64'(mk(1'b0, 1'b1, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0)));

        // Requests asserted during reset must not be offered.
        bus.x_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.x_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_data", 64'(dut_res()), 64'd0);

        // X only.
        drive(1'b0, 48'h8000_0000_0000, 8'd127, 1'b1);
        wait_out(r, lat);
        check("x_only_latency", 64'(lat - 1), 64'd2);
        check("x_only_result", 64'(r), 64'(mk(1'b0, 1'b1, 8'd128, 24'h800000, 1'b0, 1'b0, 1'b0)));

        // Y only, one leading zero.
        drive(1'b1, 48'h4000_0000_0000, 8'd127, 1'b0);
        wait_out(r, lat);
        check("y_only_result", 64'(r), 64'(mk(1'b1, 1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0)));

        // Contention: both held valid for four grants.
        @(posedge clk); #1;
        bus.x_mant = 48'h8000_0000_0000; bus.x_exp = 8'd100; bus.x_sign = 1'b0;
        bus.y_mant = 48'h0123_4567_89AB; bus.y_exp = 8'd90;  bus.y_sign = 1'b1;
        bus.x_valid = 1'b1; bus.y_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (bus.x_ready && bus.x_valid) begin ids[n] = 1'b0; tms[n] = cyc; n++; end
            else if (bus.y_ready && bus.y_valid) begin ids[n] = 1'b1; tms[n] = cyc; n++; end
        end
        @(posedge clk); #1;
        bus.x_valid = 1'b0; bus.y_valid = 1'b0;
        check("contention_grants", 64'(n), 64'd4);
        if (n == 4) begin
            check("grant_order", 64'({ids[0], ids[1], ids[2], ids[3]}), 64'(4'b0101));
            for (int i = 1; i < 4; i++) check("grant_period", 64'(tms[i] - tms[i-1]), 64'd4);
        end
        wait_out(r, lat);
        repeat (2) @(posedge clk);

        // Empty window, then underflow.
        drive(1'b0, 48'h0000_00FF_FFFF, 8'd77, 1'b1);
        wait_out(r, lat);
        check("zero_result", 64'(r), 64'(mk(1'b0, 1'b1, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0)));
        drive(1'b1, 48'h0000_0100_0000, 8'd10, 1'b0);
        wait_out(r, lat);
        check("uflow_result", 64'(r), 64'(mk(1'b1, 1'b0, 8'd0, 24'd0, 1'b0, 1'b1, 1'b0)));

        // Overflow held under backpressure while Y waits.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        drive(1'b0, 48'hC000_0000_0000, 8'd254, 1'b1);
        wait_out(r0, lat);
        check("oflow_result", 64'(r0), 64'(mk(1'b0, 1'b1, 8'd255, 24'h800000, 1'b0, 1'b0, 1'b1)));
        @(posedge clk); #1;
        bus.y_mant = 48'h2000_0000_0000; bus.y_exp = 8'd3; bus.y_sign = 1'b1; bus.y_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", 64'(dut_res()), 64'(r0));
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_readys", 64'({bus.x_ready, bus.y_ready}), 64'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) hs++;
            if (bus.y_ready && bus.y_valid) begin @(posedge clk); #1 bus.y_valid = 1'b0; end
        end
        check("bp_single_handshake", 64'(hs), 64'd1);
        wait_out(r, lat);
        check("y_after_bp", 64'(r), 64'(mk(1'b1, 1'b1, 8'd2, 24'h800000, 1'b0, 1'b0, 1'b0)));
        repeat (2) @(posedge clk);

        // Reset while the transaction is in NORM; then both contend and X must win.
        drive(1'b1, 48'h4000_0000_0000, 8'd127, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.x_valid = 1'b1; bus.y_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && n == 0; i++) begin
            @(negedge clk);
            if (bus.x_ready || bus.y_ready) begin
                n = 1;
                check("post_reset_grant", 64'({bus.x_ready, bus.y_ready}), 64'(2'b10));
            end
        end
        if (n == 0) timeout("post_reset_grant");
        @(posedge clk); #1;
        bus.x_valid = 1'b0; bus.y_valid = 1'b0;
        wait_out(r, lat);
        check("post_reset_id", 64'(r.id), 64'd0);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ax = bus.x_valid && bus.x_ready;
            ay = bus.y_valid && bus.y_ready;
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.x_valid || ax) begin
                bus.x_valid = $urandom_range(0, 1) == 1;
                bus.x_mant  = rand_mant();
                bus.x_exp   = 8'($urandom_range(0, 255));
                bus.x_sign  = 1'($urandom_range(0, 1));
            end
            if (!bus.y_valid || ay) begin
                bus.y_valid = $urandom_range(0, 1) == 1;
                bus.y_mant  = rand_mant();
                bus.y_exp   = 8'($urandom_range(0, 255));
                bus.y_sign  = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        bus.x_valid = 1'b0; bus.y_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
